// File: rtl/i2c_shift_master_if.sv
`default_nettype none
//==============================================================================
// Module   : i2c_shift_master_if
// Desc     : Request/status bundle between a client and the I2C shift master.
// Revision : 1.0
//==============================================================================
interface i2c_shift_master_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6
) ();
  localparam int c_SW = $clog2(DATAWIDTH);

  logic [DATAWIDTH-1:0] D;
  logic [c_SW-1:0]      S;
  logic [1:0]           mode;
  logic                 MSBIn;
  logic                 LSBIn;
  logic [ADDRWIDTH-1:0] addr;
  logic                 wr_en;
  logic                 rd_en;
  logic [DATAWIDTH-1:0] rd_data;
  logic                 busy;
  logic                 done;
  logic                 ack_err;
  logic                 scl;

  // Client side: issues requests, observes status and the bus clock.
  modport master (
    output D, S, mode, MSBIn, LSBIn, addr, wr_en, rd_en,
    input  rd_data, busy, done, ack_err, scl
  );

  // Engine side.
  modport slave (
    input  D, S, mode, MSBIn, LSBIn, addr, wr_en, rd_en,
    output rd_data, busy, done, ack_err, scl
  );
endinterface
`default_nettype wire

// File: rtl/i2c_shift_master.sv
`default_nettype none
//==============================================================================
// Module   : i2c_shift_master
// Desc     : Single-master I2C engine with shift/rotate transform on write data.
// Revision : 1.0
//==============================================================================
module i2c_shift_master #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6,
  parameter int CLKDIV    = 4
) (
  input  logic                clk,
  input  logic                reset,
  i2c_shift_master_if.slave   bus,
  inout  wire                 sda
);
  localparam int c_NBYTES = DATAWIDTH / 8;
  localparam int c_DIVW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [c_DIVW-1:0]    c_DIVLAST  = c_DIVW'(CLKDIV - 1);
  localparam logic [4:0]           c_LASTBYTE = 5'(c_NBYTES - 1);
  localparam logic [DATAWIDTH-1:0] c_ONES     = '1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_AACK  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_WACK  = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_RACK  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  logic [3:0]           r_state;
  logic [c_DIVW-1:0]    r_div;
  logic [1:0]           r_q;
  logic [2:0]           r_bit;
  logic [4:0]           r_byte;
  logic                 r_rw;
  logic [7:0]           r_abyte;
  logic [DATAWIDTH-1:0] r_tx;
  logic [DATAWIDTH-1:0] r_rx;
  logic [DATAWIDTH-1:0] r_rd_data;
  logic                 r_sda_smp;
  logic                 r_ack_err;
  logic                 r_done;

  logic                 w_qend;
  logic                 w_bit_end;
  logic                 w_samp;
  logic [DATAWIDTH-1:0] w_xform;
  logic                 w_scl;
  logic                 w_sda_low;

  assign w_qend    = (r_div == c_DIVLAST);
  assign w_bit_end = w_qend && (r_q == 2'd3) && (r_state != S_IDLE);
  assign w_samp    = w_qend && (r_q == 2'd2) && (r_state != S_IDLE);

  always_comb begin
    w_xform = bus.D;
    case (bus.mode)
      2'b01:   w_xform = (bus.D >> bus.S) | (bus.MSBIn ? ~(c_ONES >> bus.S) : '0);
      2'b10:   w_xform = (bus.D << bus.S) | (bus.LSBIn ? ~(c_ONES << bus.S) : '0);
      2'b11:   w_xform = (bus.D << bus.S) | (bus.D >> (DATAWIDTH - int'(bus.S)));
      default: w_xform = bus.D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_byte    <= 5'd0;
      r_rw      <= 1'b0;
      r_abyte   <= 8'd0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rd_data <= '0;
      r_sda_smp <= 1'b1;
      r_ack_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_state == S_IDLE) begin
        r_div  <= '0;
        r_q    <= 2'd0;
        r_bit  <= 3'd0;
        r_byte <= 5'd0;
        if (bus.wr_en) begin
          r_tx      <= w_xform;
          r_abyte   <= {7'(bus.addr), 1'b0};
          r_rw      <= 1'b0;
          r_ack_err <= 1'b0;
          r_state   <= S_START;
        end else if (bus.rd_en) begin
          r_abyte   <= {7'(bus.addr), 1'b1};
          r_rw      <= 1'b1;
          r_ack_err <= 1'b0;
          r_state   <= S_START;
        end
      end else if (w_qend) begin
        r_div <= '0;
        r_q   <= r_q + 2'd1;
      end else begin
        r_div <= r_div + c_DIVW'(1);
      end

      // Sample at the end of the first scl-high quarter, when the slave has settled.
      if (w_samp) begin
        r_sda_smp <= sda;
        if (r_state == S_RDATA)
          r_rx <= {r_rx[DATAWIDTH-2:0], sda};
      end

      if (w_bit_end) begin
        case (r_state)
          S_START: begin
            r_bit   <= 3'd0;
            r_state <= S_ADDR;
          end
          S_ADDR: begin
            r_abyte <= {r_abyte[6:0], 1'b0};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7)
              r_state <= S_AACK;
          end
          S_AACK: begin
            r_bit  <= 3'd0;
            r_byte <= 5'd0;
            if (r_sda_smp) begin
              r_ack_err <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_state <= r_rw ? S_RDATA : S_WDATA;
            end
          end
          S_WDATA: begin
            r_tx  <= {r_tx[DATAWIDTH-2:0], 1'b0};
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7)
              r_state <= S_WACK;
          end
          S_WACK: begin
            if (r_sda_smp) begin
              r_ack_err <= 1'b1;
              r_state   <= S_STOP;
            end else if (r_byte == c_LASTBYTE) begin
              r_state <= S_STOP;
            end else begin
              r_byte  <= r_byte + 5'd1;
              r_state <= S_WDATA;
            end
          end
          S_RDATA: begin
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7)
              r_state <= S_RACK;
          end
          S_RACK: begin
            if (r_byte == c_LASTBYTE) begin
              r_state <= S_STOP;
            end else begin
              r_byte  <= r_byte + 5'd1;
              r_state <= S_RDATA;
            end
          end
          S_STOP: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            if (r_rw && !r_ack_err)
              r_rd_data <= r_rx;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Bus pins decode straight from state and quarter; sda only moves at quarter 0
  // except for the START/STOP edges at mid bit.
  always_comb begin
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      S_START: w_sda_low = r_q[1];
      S_ADDR: begin
        w_scl     = r_q[1];
        w_sda_low = ~r_abyte[7];
      end
      S_WDATA: begin
        w_scl     = r_q[1];
        w_sda_low = ~r_tx[DATAWIDTH-1];
      end
      S_AACK, S_WACK, S_RDATA: w_scl = r_q[1];
      S_RACK: begin
        w_scl     = r_q[1];
        w_sda_low = (r_byte != c_LASTBYTE);
      end
      S_STOP: begin
        w_scl     = (r_q != 2'd0);
        w_sda_low = ~r_q[1];
      end
      default: begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
      end
    endcase
  end

  assign sda         = w_sda_low ? 1'b0 : 1'bz;
  assign bus.scl     = w_scl;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.ack_err = r_ack_err;
  assign bus.rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_shift_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_i2c_shift_master
// Desc     : Directed bench for i2c_shift_master with a behavioural I2C slave.
// Revision : 1.0
//==============================================================================
module tb_i2c_shift_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_shift_master_if #(.DATAWIDTH(8),  .ADDRWIDTH(6)) bus8  ();
  i2c_shift_master_if #(.DATAWIDTH(16), .ADDRWIDTH(6)) bus16 ();

  wire sda8;
  wire sda16;
  pullup (sda8);
  pullup (sda16);

  logic sel = 1'b0;
  logic slave_low = 1'b0;
  logic abort = 1'b0;
  logic slave_present = 1'b1;
  logic [7:0] rdata [0:1];
  logic [7:0] cap [0:3];
  int cap_n;
  int mack [0:1];

  assign sda8  = (!sel && slave_low) ? 1'b0 : 1'bz;
  assign sda16 = ( sel && slave_low) ? 1'b0 : 1'bz;
  wire w_scl = sel ? bus16.scl : bus8.scl;
  wire w_sda = sel ? sda16 : sda8;

  i2c_shift_master #(.DATAWIDTH(8), .ADDRWIDTH(6), .CLKDIV(4)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .sda(sda8)
  );
  i2c_shift_master #(.DATAWIDTH(16), .ADDRWIDTH(6), .CLKDIV(4)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16), .sda(sda16)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  task automatic wait_pos(output bit ab);
    @(posedge w_scl or posedge abort);
    ab = abort;
  endtask

  task automatic wait_neg(output bit ab);
    @(negedge w_scl or posedge abort);
    ab = abort;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ab);
    b = 8'd0;
    ab = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_pos(ab);
      if (ab) return;
      b = {b[6:0], w_sda};
    end
    if (cap_n < 4) begin
      cap[cap_n] = b;
      cap_n++;
    end
  endtask

  task automatic slave_txn();
    logic [7:0] b;
    bit ab;
    int nb;
    nb = sel ? 2 : 1;
    recv_byte(b, ab);
    if (ab) return;
    wait_neg(ab);
    if (ab || !slave_present) return;
    slave_low = 1'b1;
    wait_neg(ab);
    slave_low = 1'b0;
    if (ab) return;
    for (int k = 0; k < nb; k++) begin
      if (!b[0]) begin
        recv_byte(b, ab);
        if (ab) return;
        wait_neg(ab);
        if (ab) return;
        slave_low = 1'b1;
        wait_neg(ab);
        slave_low = 1'b0;
        if (ab) return;
        b = 8'd0;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          slave_low = ~rdata[k][i];
          wait_pos(ab);
          if (ab) return;
          wait_neg(ab);
          if (ab) return;
        end
        slave_low = 1'b0;
        wait_pos(ab);
        if (ab) return;
        mack[k] = int'(w_sda);
        wait_neg(ab);
        if (ab) return;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge w_sda);
      if (w_scl === 1'b1 && !abort) begin
        slave_txn();
        slave_low = 1'b0;
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic set_req(input bit s16, input bit w, input bit r);
    if (s16) begin
      bus16.wr_en = w;
      bus16.rd_en = r;
    end else begin
      bus8.wr_en = w;
      bus8.rd_en = r;
    end
  endtask

  task automatic do_txn(input bit s16, input bit wr, input bit rd, input logic [15:0] d,
                        input logic [3:0] s, input logic [1:0] m, input bit msb, input bit lsb,
                        input logic [5:0] a, input int inject_at,
                        output int cyc, output bit busy_bad);
    logic dn;
    logic bz;
    sel = s16;
    cap_n = 0;
    mack[0] = -1;
    mack[1] = -1;
    busy_bad = 1'b0;
    @(negedge clk);
    if (s16) begin
      bus16.D = d; bus16.S = s; bus16.mode = m;
      bus16.MSBIn = msb; bus16.LSBIn = lsb; bus16.addr = a;
    end else begin
      bus8.D = d[7:0]; bus8.S = s[2:0]; bus8.mode = m;
      bus8.MSBIn = msb; bus8.LSBIn = lsb; bus8.addr = a;
    end
    set_req(s16, wr, rd);
    @(posedge clk);
    #1;
    set_req(s16, 1'b0, 1'b0);
    bz = s16 ? bus16.busy : bus8.busy;
    if (!bz) busy_bad = 1'b1;
    cyc = 0;
    dn = 1'b0;
    while (!dn && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      dn = s16 ? bus16.done : bus8.done;
      bz = s16 ? bus16.busy : bus8.busy;
      if (dn == bz) busy_bad = 1'b1;
      if (cyc == inject_at) set_req(s16, 1'b1, 1'b1);
      else if (cyc == inject_at + 1) set_req(s16, 1'b0, 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  int  cyc;
  bit  bb;

  initial begin
    bus8.D = '0;  bus8.S = '0;  bus8.mode = 2'b00;  bus8.MSBIn = 1'b0;  bus8.LSBIn = 1'b0;
    bus8.addr = '0;  bus8.wr_en = 1'b0;  bus8.rd_en = 1'b0;
    bus16.D = '0; bus16.S = '0; bus16.mode = 2'b00; bus16.MSBIn = 1'b0; bus16.LSBIn = 1'b0;
    bus16.addr = '0; bus16.wr_en = 1'b0; bus16.rd_en = 1'b0;
    rdata[0] = 8'h00;
    rdata[1] = 8'h00;
    cap_n = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_scl",     32'(bus8.scl), 32'd1);
    check_eq("rst_sda",     32'(w_sda), 32'd1);
    check_eq("rst_busy",    32'(bus8.busy), 32'd0);
    check_eq("rst_done",    32'(bus8.done), 32'd0);
    check_eq("rst_ackerr",  32'(bus8.ack_err), 32'd0);
    check_eq("rst_rdata8",  32'(bus8.rd_data), 32'd0);
    check_eq("rst_rdata16", 32'(bus16.rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // write, mode 01: 0xE5 >> 1 with MSB fill -> 0xF2
    slave_present = 1'b1;
    do_txn(1'b0, 1'b1, 1'b0, 16'h00E5, 4'd1, 2'b01, 1'b1, 1'b0, 6'h0D, -1, cyc, bb);
    check_eq("w1_cycles", 32'(cyc), 32'd320);
    check_eq("w1_busy",   32'(bb), 32'd0);
    check_eq("w1_ncap",   32'(cap_n), 32'd2);
    check_eq("w1_addr",   32'(cap[0]), 32'h1A);
    check_eq("w1_data",   32'(cap[1]), 32'hF2);
    check_eq("w1_ackerr", 32'(bus8.ack_err), 32'd0);
    @(posedge clk);
    #1;
    check_eq("w1_done_pulse", 32'(bus8.done), 32'd0);
    check_eq("w1_idle_scl",   32'(bus8.scl), 32'd1);
    check_eq("w1_idle_sda",   32'(w_sda), 32'd1);

    // read 8-bit
    rdata[0] = 8'hA5;
    do_txn(1'b0, 1'b0, 1'b1, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 6'h13, -1, cyc, bb);
    check_eq("r1_cycles", 32'(cyc), 32'd320);
    check_eq("r1_busy",   32'(bb), 32'd0);
    check_eq("r1_addr",   32'(cap[0]), 32'h27);
    check_eq("r1_rdata",  32'(bus8.rd_data), 32'hA5);
    check_eq("r1_mnack",  32'(mack[0]), 32'd1);

    // no slave: address NACK on write, then on read
    slave_present = 1'b0;
    do_txn(1'b0, 1'b1, 1'b0, 16'h005A, 4'd0, 2'b00, 1'b0, 1'b0, 6'h0D, -1, cyc, bb);
    check_eq("n1_cycles", 32'(cyc), 32'd176);
    check_eq("n1_addr",   32'(cap[0]), 32'h1A);
    check_eq("n1_ackerr", 32'(bus8.ack_err), 32'd1);
    check_eq("n1_sda",    32'(w_sda), 32'd1);
    do_txn(1'b0, 1'b0, 1'b1, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 6'h13, -1, cyc, bb);
    check_eq("n2_cycles", 32'(cyc), 32'd176);
    check_eq("n2_rdata_kept", 32'(bus8.rd_data), 32'hA5);
    check_eq("n2_ackerr", 32'(bus8.ack_err), 32'd1);

    // write, mode 10: 0x81 << 3 with LSB fill -> 0x0F; ack_err clears
    slave_present = 1'b1;
    do_txn(1'b0, 1'b1, 1'b0, 16'h0081, 4'd3, 2'b10, 1'b0, 1'b1, 6'h05, -1, cyc, bb);
    check_eq("w2_addr",   32'(cap[0]), 32'h0A);
    check_eq("w2_data",   32'(cap[1]), 32'h0F);
    check_eq("w2_ackerr", 32'(bus8.ack_err), 32'd0);

    // wr+rd together -> write wins (pass mode), second request while busy ignored
    do_txn(1'b0, 1'b1, 1'b1, 16'h003C, 4'd2, 2'b00, 1'b1, 1'b1, 6'h21, 100, cyc, bb);
    check_eq("c_cycles", 32'(cyc), 32'd320);
    check_eq("c_addr",   32'(cap[0]), 32'h42);
    check_eq("c_data",   32'(cap[1]), 32'h3C);
    repeat (30) @(posedge clk);
    #1;
    check_eq("c_no_second_busy", 32'(bus8.busy), 32'd0);
    check_eq("c_no_second_cap",  32'(cap_n), 32'd2);

    // 16-bit write, rotate left by 4: 0x1234 -> 0x2341
    do_txn(1'b1, 1'b1, 1'b0, 16'h1234, 4'd4, 2'b11, 1'b0, 1'b0, 6'h0D, -1, cyc, bb);
    check_eq("w16_cycles", 32'(cyc), 32'd464);
    check_eq("w16_busy",   32'(bb), 32'd0);
    check_eq("w16_ncap",   32'(cap_n), 32'd3);
    check_eq("w16_b0",     32'(cap[1]), 32'h23);
    check_eq("w16_b1",     32'(cap[2]), 32'h41);

    // 16-bit read: master ACKs byte 1, NACKs byte 2
    rdata[0] = 8'hA5;
    rdata[1] = 8'h3C;
    do_txn(1'b1, 1'b0, 1'b1, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 6'h13, -1, cyc, bb);
    check_eq("r16_cycles", 32'(cyc), 32'd464);
    check_eq("r16_rdata",  32'(bus16.rd_data), 32'hA53C);
    check_eq("r16_mack0",  32'(mack[0]), 32'd0);
    check_eq("r16_mack1",  32'(mack[1]), 32'd1);

    // reset in the middle of WDATA, with a request in the reset cycle
    sel = 1'b0;
    cap_n = 0;
    @(negedge clk);
    bus8.D = 8'hE5; bus8.S = 3'd1; bus8.mode = 2'b01; bus8.MSBIn = 1'b1; bus8.addr = 6'h0D;
    bus8.wr_en = 1'b1;
    @(posedge clk);
    #1;
    bus8.wr_en = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    abort = 1'b1;
    bus8.wr_en = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mr_scl",    32'(bus8.scl), 32'd1);
    check_eq("mr_sda",    32'(w_sda), 32'd1);
    check_eq("mr_busy",   32'(bus8.busy), 32'd0);
    check_eq("mr_done",   32'(bus8.done), 32'd0);
    check_eq("mr_rdata",  32'(bus8.rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus8.wr_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mr_req_ignored", 32'(bus8.busy), 32'd0);
    abort = 1'b0;
    repeat (4) @(posedge clk);
    do_txn(1'b0, 1'b1, 1'b0, 16'h00E5, 4'd1, 2'b01, 1'b1, 1'b0, 6'h0D, -1, cyc, bb);
    check_eq("mr_w_cycles", 32'(cyc), 32'd320);
    check_eq("mr_w_addr",   32'(cap[0]), 32'h1A);
    check_eq("mr_w_data",   32'(cap[1]), 32'hF2);
    check_eq("mr_w_ackerr", 32'(bus8.ack_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/i2c_shift_master.md
I2C_SHIFT_MASTER -- requirements
Module: i2c_shift_master

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, payload width in bits; legal values are multiples of 8; NBYTES = DATAWIDTH/8.
REQ-002 SHALL have parameter ADDRWIDTH, default 6, target address width; legal range 1..7; zero-extended to a 7-bit I2C address.
REQ-003 SHALL have parameter CLKDIV, default 4, number of clk cycles per SCL quarter-period; minimum 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port D, input, DATAWIDTH, write payload.
REQ-007 SHALL have port S, input, $clog2(DATAWIDTH), shift/rotate amount.
REQ-008 SHALL have port mode, input, 2, payload transform: 00 pass, 01 shift right, 10 shift left, 11 rotate left.
REQ-009 SHALL have port MSBIn, input, 1, fill bit for shift right.
REQ-010 SHALL have port LSBIn, input, 1, fill bit for shift left.
REQ-011 SHALL have port addr, input, ADDRWIDTH, target address.
REQ-012 SHALL have port wr_en, input, 1, one-cycle write request.
REQ-013 SHALL have port rd_en, input, 1, one-cycle read request.
REQ-014 SHALL have port rd_data, output, DATAWIDTH, read result, first byte received in MSBs.
REQ-015 SHALL have ports busy, done and ack_err, each output, 1: transaction active, one-cycle completion pulse, NACK seen in the last transaction.
REQ-016 SHALL have port scl, output, 1, push-pull I2C clock, with no clock stretching supported.
REQ-017 SHALL have port sda, inout, 1, open-drain: driven to 0 or z only, never to 1.

Function
REQ-018 SHALL capture addr and the transformed D on the clk edge where wr_en=1 and busy=0; transformed D = D, D>>S with S MSBs set to MSBIn, D<<S with S LSBs set to LSBIn, or rotate-left by S, according to mode.
REQ-019 SHALL capture addr on the clk edge where rd_en=1, wr_en=0 and busy=0; when both wr_en and rd_en are 1 the write wins; requests while busy=1 SHALL be ignored.
REQ-020 SHALL use one bit-time of 4*CLKDIV clk cycles, made of four quarters: scl low, low, high, high.
REQ-021 SHALL change sda only in quarter 0 and sample sda at the end of quarter 2.
REQ-022 SHALL implement FSM states IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RACK, STOP.
REQ-023 SHALL sequence IDLE->START on an accepted request.
REQ-024 SHALL, in START (1 bit-time), hold scl=1 and pull sda low at mid bit.
REQ-025 SHALL, in ADDR, send 8 bits MSB-first: 7-bit address then R/W, with W=0 and R=1.
REQ-026 SHALL, in AACK, release sda and sample; 1 (NACK) -> set ack_err and go to STOP; 0 -> go to WDATA or RDATA.
REQ-027 SHALL, in WDATA, send the current byte MSB-first starting from the payload MSBs.
REQ-028 SHALL, in WACK, sample ACK; NACK -> ack_err=1 and STOP; ACK -> next byte, or STOP after byte NBYTES.
REQ-029 SHALL, in RDATA, release sda and shift in 8 bits.
REQ-030 SHALL, in RACK, drive ACK (sda low) for bytes 1..NBYTES-1 and NACK (release) after the last byte, then go to STOP.
REQ-031 SHALL, in STOP (1 bit-time), hold sda low, raise scl, then release sda at mid bit.
REQ-032 SHALL, on STOP end, return to IDLE and pulse done=1 for exactly one cycle.
REQ-033 SHALL update rd_data only at a read done, and leave it unchanged after a NACK-aborted read.
REQ-034 SHALL have a transaction length of (2 + 9 + 9*NBYTES) bit-times from the accept edge; busy=1 from the cycle after accept through the cycle before done; busy=0 on the done cycle.
REQ-035 SHALL clear ack_err at each accepted request.
REQ-036 SHALL keep the bit counter and byte counter wide enough for NBYTES up to 16, with no wrap inside a transaction.

Reset
REQ-037 SHALL, when reset=1 at a clk edge, force IDLE with scl=1, sda released, busy=0, done=0, ack_err=0 and rd_data=0, including mid-transaction.
REQ-038 SHALL, when reset=1, abandon any in-flight transaction without issuing STOP.
REQ-039 SHALL ignore requests asserted in the same cycle as reset.

Verification
REQ-040 SHALL cover this scenario: write with DATAWIDTH=8, addr=6'h0D, D=8'hE5, mode=01, S=1, MSBIn=1, slave ACKs -> SDA carries 0x1A then 0xF2; done after 20 bit-times (320 clk at CLKDIV=4); ack_err=0.
REQ-041 SHALL cover this scenario: read with addr=6'h13, slave returns 0xA5 -> address byte 0x27; rd_data=8'hA5 at done; master NACKs the final byte.
REQ-042 SHALL cover this scenario: write to addr=6'h0D with no slave (sda pulled up) -> ack_err=1 after AACK; STOP issued; done after 11 bit-times.
REQ-043 SHALL cover this scenario: DATAWIDTH=16, mode=11, S=4, D=16'h1234 -> bytes 0x23 then 0x41 sent; master ACKs read byte 1 and NACKs byte 2.
REQ-044 SHALL cover this scenario: wr_en and rd_en together, then wr_en while busy -> a single write occurs; the second request is ignored.
REQ-045 SHALL cover this scenario: reset asserted mid-WDATA -> next cycle scl=1, sda=z, busy=0; a new write afterwards completes normally.
